// File: rtl/imm_gen_pipe.sv
// Two-stage pipelined RV32I/RV64I immediate generator with valid/ready on both sides.
// Define IMM_GEN_CSR_EN to decode SYSTEM (CSR) opcodes; otherwise they are illegal.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FmtI    = 3'd0,
    FmtS    = 3'd1,
    FmtB    = 3'd2,
    FmtU    = 3'd3,
    FmtJ    = 3'd4,
    FmtZ    = 3'd5,
    FmtNone = 3'd7
  } fmt_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
`ifdef IMM_GEN_CSR_EN
  localparam logic [6:0] OpSystem = 7'b1110011;
`endif

  // Stage-1 state
  logic             s1_valid_q,   s1_valid_d;
  logic [31:7]      s1_instr_q,   s1_instr_d;
  logic [TAG_W-1:0] s1_tag_q,     s1_tag_d;
  fmt_e             s1_fmt_q,     s1_fmt_d;
  logic             s1_illegal_q, s1_illegal_d;
  logic             s1_shamt_q,   s1_shamt_d;
  logic             s1_sh6_q,     s1_sh6_d;

  // Stage-2 state
  logic             s2_valid_q,   s2_valid_d;
  logic [XLEN-1:0]  s2_imm_q,     s2_imm_d;
  fmt_e             s2_fmt_q,     s2_fmt_d;
  logic             s2_illegal_q, s2_illegal_d;
  logic [TAG_W-1:0] s2_tag_q,     s2_tag_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

  logic s1_load, s2_load, in_fire, out_fire;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = !flush && s1_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  // Opcode decode on the incoming word
  logic [6:0] in_opc;
  logic [2:0] in_f3;
  logic       is_shift_f3;
  fmt_e       dec_fmt;
  logic       dec_shamt, dec_sh6;

  assign in_opc      = in_instr[6:0];
  assign in_f3       = in_instr[14:12];
  assign is_shift_f3 = (in_f3 == 3'b001) || (in_f3 == 3'b101);

  always_comb begin
    dec_fmt   = FmtNone;
    dec_shamt = 1'b0;
    dec_sh6   = 1'b0;
    case (in_opc)
      OpLoad, OpJalr: dec_fmt = FmtI;
      OpImm: begin
        dec_fmt   = FmtI;
        dec_shamt = is_shift_f3;
        dec_sh6   = (XLEN == 64);
      end
      // Word-sized ops exist only on RV64; shamt is always 5 bits here.
      OpImm32: begin
        if (XLEN == 64) begin
          dec_fmt   = FmtI;
          dec_shamt = is_shift_f3;
        end
      end
      OpStore:         dec_fmt = FmtS;
      OpBranch:        dec_fmt = FmtB;
      OpLui, OpAuipc:  dec_fmt = FmtU;
      OpJal:           dec_fmt = FmtJ;
`ifdef IMM_GEN_CSR_EN
      OpSystem:        dec_fmt = in_f3[2] ? FmtZ : FmtI;
`endif
      default:         dec_fmt = FmtNone;
    endcase
  end

  // Immediate assembly on the stage-1 word
  logic signed [31:0] asm_imm;

  always_comb begin
    asm_imm = '0;
    case (s1_fmt_q)
      FmtI: begin
        if (s1_shamt_q) begin
          asm_imm = s1_sh6_q ? {26'b0, s1_instr_q[25:20]} : {27'b0, s1_instr_q[24:20]};
        end else begin
          asm_imm = {{20{s1_instr_q[31]}}, s1_instr_q[31:20]};
        end
      end
      FmtS: asm_imm = {{20{s1_instr_q[31]}}, s1_instr_q[31:25], s1_instr_q[11:7]};
      FmtB: asm_imm = {{19{s1_instr_q[31]}}, s1_instr_q[31], s1_instr_q[7],
                       s1_instr_q[30:25], s1_instr_q[11:8], 1'b0};
      FmtU: asm_imm = {s1_instr_q[31:12], 12'b0};
      FmtJ: asm_imm = {{11{s1_instr_q[31]}}, s1_instr_q[31], s1_instr_q[19:12],
                       s1_instr_q[20], s1_instr_q[30:21], 1'b0};
`ifdef IMM_GEN_CSR_EN
      FmtZ: asm_imm = {27'b0, s1_instr_q[19:15]};
`endif
      default: asm_imm = '0;
    endcase
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_instr_d   = s1_instr_q;
    s1_tag_d     = s1_tag_q;
    s1_fmt_d     = s1_fmt_q;
    s1_illegal_d = s1_illegal_q;
    s1_shamt_d   = s1_shamt_q;
    s1_sh6_d     = s1_sh6_q;
    if (s1_load) begin
      s1_valid_d = in_fire;
      if (in_fire) begin
        s1_instr_d   = in_instr[31:7];
        s1_tag_d     = in_tag;
        s1_fmt_d     = dec_fmt;
        s1_illegal_d = (dec_fmt == FmtNone);
        s1_shamt_d   = dec_shamt;
        s1_sh6_d     = dec_sh6;
      end
    end
    if (flush) begin
      s1_valid_d = 1'b0;
    end
  end

  // Output registers only change when a real word moves in, so a bubble keeps them stable.
  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_imm_d     = s2_imm_q;
    s2_fmt_d     = s2_fmt_q;
    s2_illegal_d = s2_illegal_q;
    s2_tag_d     = s2_tag_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_imm_d     = XLEN'(asm_imm);
        s2_fmt_d     = s1_fmt_q;
        s2_illegal_d = s1_illegal_q;
        s2_tag_d     = s1_tag_q;
      end
    end
    if (flush) begin
      s2_valid_d = 1'b0;
    end
  end

  // A word handshaking in a flush cycle has still been delivered, so it is counted.
  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && s2_illegal_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_instr_q   <= '0;
      s1_tag_q     <= '0;
      s1_fmt_q     <= FmtNone;
      s1_illegal_q <= 1'b0;
      s1_shamt_q   <= 1'b0;
      s1_sh6_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_imm_q     <= '0;
      s2_fmt_q     <= FmtNone;
      s2_illegal_q <= 1'b0;
      s2_tag_q     <= '0;
      cnt_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_instr_q   <= s1_instr_d;
      s1_tag_q     <= s1_tag_d;
      s1_fmt_q     <= s1_fmt_d;
      s1_illegal_q <= s1_illegal_d;
      s1_shamt_q   <= s1_shamt_d;
      s1_sh6_q     <= s1_sh6_d;
      s2_valid_q   <= s2_valid_d;
      s2_imm_q     <= s2_imm_d;
      s2_fmt_q     <= s2_fmt_d;
      s2_illegal_q <= s2_illegal_d;
      s2_tag_q     <= s2_tag_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_imm     = s2_imm_q;
  assign out_fmt     = s2_fmt_q;
  assign out_illegal = s2_illegal_q;
  assign out_tag     = s2_tag_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV64 and an RV32 instance share one stimulus stream,
// results are checked through a scoreboard against a table of hand-decoded immediates.
module tb_imm_gen_pipe;

  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, out_ready;
  logic [31:0]     in_instr;
  logic [7:0]      in_tag;

  logic            rdy64, rdy32;
  logic            o64_valid, o32_valid;
  logic [63:0]     o64_imm;
  logic [31:0]     o32_imm;
  logic [2:0]      o64_fmt, o32_fmt;
  logic            o64_ill, o32_ill;
  logic [7:0]      o64_tag, o32_tag;
  logic [CntW-1:0] cnt64, cnt32;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(CntW)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(o64_valid), .out_ready(out_ready),
    .out_imm(o64_imm), .out_fmt(o64_fmt), .out_illegal(o64_ill), .out_tag(o64_tag),
    .illegal_cnt(cnt64)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(CntW)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(o32_valid), .out_ready(out_ready),
    .out_imm(o32_imm), .out_fmt(o32_fmt), .out_illegal(o32_ill), .out_tag(o32_tag),
    .illegal_cnt(cnt32)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic [7:0] tag;
  } exp_t;

  localparam int NVec = 17;
  vec_t vecs [NVec];
  exp_t sb [$];
  vec_t cur_v;
  logic [7:0] tag_n = 8'd0;
  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;
  logic [CntW-1:0] exp_cnt64 = '0;
  logic [CntW-1:0] exp_cnt32 = '0;
  logic hold = 1'b0;
  logic [63:0] hold_imm;
  logic [7:0] hold_tag;

  function automatic vec_t mk(input logic [31:0] instr, input logic [63:0] i64,
                              input logic [2:0] f64, input logic l64, input logic [31:0] i32,
                              input logic [2:0] f32, input logic l32);
    vec_t v;
    v.instr = instr; v.imm64 = i64; v.fmt64 = f64; v.ill64 = l64;
    v.imm32 = i32; v.fmt32 = f32; v.ill32 = l32;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: push on accepted input, pop and compare on output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("cnt64", 64'(cnt64), 64'(exp_cnt64));
      chk("cnt32", 64'(cnt32), 64'(exp_cnt32));
      if (reset) begin
        sb.delete();
        exp_cnt64 = '0;
        exp_cnt32 = '0;
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_imm", o64_imm, hold_imm);
          chk("hold_tag", 64'(o64_tag), 64'(hold_tag));
        end
        if (o64_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out: got tag %h expected no output", o64_tag);
          end else begin
            e = sb.pop_front();
            chk("imm64", o64_imm, e.v.imm64);
            chk("fmt64", 64'(o64_fmt), 64'(e.v.fmt64));
            chk("ill64", 64'(o64_ill), 64'(e.v.ill64));
            chk("tag64", 64'(o64_tag), 64'(e.tag));
            chk("valid32", 64'(o32_valid), 64'd1);
            chk("imm32", 64'(o32_imm), 64'(e.v.imm32));
            chk("fmt32", 64'(o32_fmt), 64'(e.v.fmt32));
            chk("ill32", 64'(o32_ill), 64'(e.v.ill32));
            chk("tag32", 64'(o32_tag), 64'(e.tag));
            if (e.v.ill64 && exp_cnt64 != {CntW{1'b1}}) exp_cnt64 = exp_cnt64 + 1'b1;
            if (e.v.ill32 && exp_cnt32 != {CntW{1'b1}}) exp_cnt32 = exp_cnt32 + 1'b1;
          end
        end
        hold = o64_valid && !out_ready && !flush;
        hold_imm = o64_imm;
        hold_tag = o64_tag;
        if (flush) sb.delete();
        else if (in_valid && rdy64) sb.push_back('{v: cur_v, tag: in_tag});
      end
    end
  end

  task automatic present(input vec_t v);
    cur_v = v; in_instr = v.instr; in_tag = tag_n; in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    int n;
    logic acc;
    n = 0; acc = 1'b0;
    present(v);
    while (!acc && n < 40) begin
      @(negedge clk); acc = rdy64;
      @(posedge clk); #1; n++;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected accept", n);
    end
    tag_n++;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] first_tag;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;

    vecs[0]  = mk(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0, 32'hFFFF_FFFF, 3'd0, 1'b0);
    vecs[1]  = mk(32'h00513423, 64'h8, 3'd1, 1'b0, 32'h8, 3'd1, 1'b0);
    vecs[2]  = mk(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0, 32'hFFFF_FFFC, 3'd2, 1'b0);
    vecs[3]  = mk(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd3, 1'b0, 32'h8000_0000, 3'd3, 1'b0);
    vecs[4]  = mk(32'h03F01093, 64'h3F, 3'd0, 1'b0, 32'h1F, 3'd0, 1'b0);
    vecs[5]  = mk(32'h01F01093, 64'h1F, 3'd0, 1'b0, 32'h1F, 3'd0, 1'b0);
    vecs[6]  = mk(32'h0000007F, 64'h0, 3'd7, 1'b1, 32'h0, 3'd7, 1'b1);
    vecs[7]  = mk(32'hFF9FF06F, 64'hFFFF_FFFF_FFFF_FFF8, 3'd4, 1'b0, 32'hFFFF_FFF8, 3'd4, 1'b0);
    vecs[8]  = mk(32'h00001297, 64'h1000, 3'd3, 1'b0, 32'h1000, 3'd3, 1'b0);
    vecs[9]  = mk(32'h0011809B, 64'h1, 3'd0, 1'b0, 32'h0, 3'd7, 1'b1);
    vecs[10] = mk(32'h4210D09B, 64'h1, 3'd0, 1'b0, 32'h0, 3'd7, 1'b1);
    vecs[11] = mk(32'h4030D093, 64'h3, 3'd0, 1'b0, 32'h3, 3'd0, 1'b0);
    vecs[12] = mk(32'h80002083, 64'hFFFF_FFFF_FFFF_F800, 3'd0, 1'b0, 32'hFFFF_F800, 3'd0, 1'b0);
    vecs[13] = mk(32'h00008067, 64'h0, 3'd0, 1'b0, 32'h0, 3'd0, 1'b0);
    vecs[14] = mk(32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0, 32'hFFFF_FFFC, 3'd1, 1'b0);
`ifdef IMM_GEN_CSR_EN
    vecs[15] = mk(32'h3407D073, 64'hF, 3'd5, 1'b0, 32'hF, 3'd5, 1'b0);
    vecs[16] = mk(32'h34029073, 64'h340, 3'd0, 1'b0, 32'h340, 3'd0, 1'b0);
`else
    vecs[15] = mk(32'h3407D073, 64'h0, 3'd7, 1'b1, 32'h0, 3'd7, 1'b1);
    vecs[16] = mk(32'h34029073, 64'h0, 3'd7, 1'b1, 32'h0, 3'd7, 1'b1);
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(o64_valid), 64'd0);
    chk("rst_imm", o64_imm, 64'd0);
    chk("rst_fmt", 64'(o64_fmt), 64'd7);
    chk("rst_ill", 64'(o64_ill), 64'd0);
    chk("rst_tag", 64'(o64_tag), 64'd0);
    chk("rst_cnt", 64'(cnt64), 64'd0);
    chk("rst_ready", 64'(rdy64), 64'd1);
    chk("rst_valid32", 64'(o32_valid), 64'd0);
    chk("rst_fmt32", 64'(o32_fmt), 64'd7);
    @(posedge clk); #1;
    reset = 1'b0; mon_en = 1'b1;

    // Latency: accepted at edge N, valid visible after N+1, handshake at N+2
    present(vecs[0]);
    @(negedge clk); chk("lat_accept", 64'(rdy64), 64'd1);
    @(posedge clk); #1; in_valid = 1'b0; tag_n++;
    @(negedge clk); chk("lat_n1", 64'(o64_valid), 64'd0);
    @(negedge clk); chk("lat_n2", 64'(o64_valid), 64'd1);
    @(posedge clk); #1;

    // Single illegal word bumps the counter from 0 to 1
    chk("cnt_before", 64'(cnt64), 64'd0);
    send(vecs[6]);
    drain();
    chk("cnt_after", 64'(cnt64), 64'd1);

    // Whole table back to back
    for (int i = 0; i < NVec; i++) send(vecs[i]);
    drain();

    // Backpressure: two words fill the pipe, third is held off
    out_ready = 1'b0;
    first_tag = tag_n;
    send(vecs[1]);
    send(vecs[2]);
    present(vecs[3]);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(rdy64), 64'd0);
      chk("bp_out_tag", 64'(o64_tag), 64'(first_tag));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(vecs[3]);
    send(vecs[7]);
    drain();

    // Flush with two words in flight and a third presented
    out_ready = 1'b0;
    send(vecs[4]);
    send(vecs[5]);
    present(vecs[8]);
    flush = 1'b1;
    @(negedge clk); chk("flush_in_ready", 64'(rdy64), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; tag_n++; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk); chk("flush_no_out", 64'(o64_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Reset mid-stream discards in-flight words and clears the counter
    out_ready = 1'b0;
    send(vecs[6]);
    send(vecs[2]);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mrst_valid", 64'(o64_valid), 64'd0);
    chk("mrst_fmt", 64'(o64_fmt), 64'd7);
    chk("mrst_imm", o64_imm, 64'd0);
    chk("mrst_cnt", 64'(cnt64), 64'd0);
    repeat (3) begin
      @(negedge clk); chk("mrst_no_out", 64'(o64_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Illegal word handshaking during a flush is still counted
    send(vecs[6]);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk); chk("fcnt_valid", 64'(o64_valid), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fcnt_cnt64", 64'(cnt64), 64'd1);
    chk("fcnt_cnt32", 64'(cnt32), 64'd1);
    @(negedge clk); chk("fcnt_empty", 64'(o64_valid), 64'd0);
    @(posedge clk); #1;

    // Counter saturation
    for (int i = 0; i < 20; i++) send(vecs[6]);
    drain();
    chk("sat_cnt64", 64'(cnt64), 64'hF);
    chk("sat_cnt32", 64'(cnt32), 64'hF);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
